branch_predictor: RTL and testbench

Fetch-side dynamic branch predictor for the pipelined RV32I core. In Fetch it looks up the current PC and supplies a predicted next PC. In Execute it takes the resolved outcome of each conditional branch, trains its table, and flags mispredictions so the hazard unit can flush and redirect. It holds a direct-mapped branch target buffer with a 2-bit saturating counter per entry, plus saturating branch and mispredict statistics counters.

---
 rtl/branch_predictor_if.sv | 27 ++
 rtl/branch_predictor.sv | 80 ++++++++
 tb/tb_branch_predictor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/Execute signal bundle between the pipeline (master) and the branch predictor (slave).
// Purely combinational wiring; the predictor never stalls the pipeline.
interface branch_predictor_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PCNextPredF;
  logic [31:0] PCE;
  logic        BranchE;
  logic        NeedBranchE;
  logic [31:0] PCTargetE;
  logic        PredTakenE;
  logic [31:0] PCNextPredE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [15:0] BranchCount;
  logic [15:0] MispredCount;

  modport slave (
    input  PCF, PCE, BranchE, NeedBranchE, PCTargetE, PredTakenE, PCNextPredE,
    output PredTakenF, PCNextPredF, MispredictE, RedirectPCE, BranchCount, MispredCount
  );

  modport master (
    output PCF, PCE, BranchE, NeedBranchE, PCTargetE, PredTakenE, PCNextPredE,
    input  PredTakenF, PCNextPredF, MispredictE, RedirectPCE, BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: 0-cycle lookup in Fetch, 0-cycle resolve and
// next-edge training in Execute, saturating branch/mispredict stats; no backpressure.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

  logic            r_valid  [ENTRIES];
  logic [TW-1:0]   r_tag    [ENTRIES];
  logic [31:0]     r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic [15:0]     r_branch_cnt;
  logic [15:0]     r_mispred_cnt;

  logic [IDX-1:0]  w_f_idx;
  logic [IDX-1:0]  w_e_idx;
  logic            w_f_hit;
  logic            w_e_hit;
  logic            w_pred_taken;
  logic            w_mispredict;

  assign w_f_idx      = bp.PCF[IDX+1:2];
  assign w_e_idx      = bp.PCE[IDX+1:2];
  assign w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == bp.PCF[31:IDX+2]);
  assign w_e_hit      = r_valid[w_e_idx] && (r_tag[w_e_idx] == bp.PCE[31:IDX+2]);
  assign w_pred_taken = w_f_hit && r_ctr[w_f_idx][1];

  assign bp.PredTakenF  = w_pred_taken;
  assign bp.PCNextPredF = w_pred_taken ? r_target[w_f_idx] : bp.PCF + 32'd4;

  // A taken branch also mispredicts when the carried-down target was stale.
  assign w_mispredict = bp.BranchE &&
                        ((bp.PredTakenE != bp.NeedBranchE) ||
                         (bp.NeedBranchE && (bp.PCNextPredE != bp.PCTargetE)));
  assign bp.MispredictE  = w_mispredict;
  assign bp.RedirectPCE  = bp.NeedBranchE ? bp.PCTargetE : bp.PCE + 32'd4;
  assign bp.BranchCount  = r_branch_cnt;
  assign bp.MispredCount = r_mispred_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (bp.BranchE) begin
      if (w_e_hit) begin
        if (bp.NeedBranchE) begin
          if (r_ctr[w_e_idx] != 2'd3) r_ctr[w_e_idx] <= r_ctr[w_e_idx] + 2'd1;
          r_target[w_e_idx] <= bp.PCTargetE;
        end else if (r_ctr[w_e_idx] != 2'd0) begin
          r_ctr[w_e_idx] <= r_ctr[w_e_idx] - 2'd1;
        end
      end else if (bp.NeedBranchE) begin
        // Taken miss evicts whatever aliased into this slot.
        r_valid[w_e_idx]  <= 1'b1;
        r_tag[w_e_idx]    <= bp.PCE[31:IDX+2];
        r_target[w_e_idx] <= bp.PCTargetE;
        r_ctr[w_e_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (bp.BranchE && (r_branch_cnt != 16'hFFFF))   r_branch_cnt  <= r_branch_cnt + 16'd1;
      if (w_mispredict && (r_mispred_cnt != 16'hFFFF)) r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: inputs change 1ns after a rising edge, outputs are checked 3ns after.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic br(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                    input logic ptaken, input logic [31:0] pnext);
    bp.BranchE     = 1'b1;
    bp.PCE         = pc;
    bp.NeedBranchE = taken;
    bp.PCTargetE   = tgt;
    bp.PredTakenE  = ptaken;
    bp.PCNextPredE = pnext;
  endtask

  task automatic idle();
    bp.BranchE     = 1'b0;
    bp.NeedBranchE = 1'b0;
    bp.PredTakenE  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bp.PCF = 32'h100;
    bp.PCE = 32'h0;
    bp.PCTargetE = 32'h0;
    bp.PCNextPredE = 32'h0;
    idle();

    // Reset state
    #3;
    chk("rst_pred", {31'd0, bp.PredTakenF}, 32'd0);
    chk("rst_next", bp.PCNextPredF, 32'h104);
    chk("rst_bcnt", {16'd0, bp.BranchCount}, 32'd0);
    chk("rst_mcnt", {16'd0, bp.MispredCount}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Cold miss, taken; same-cycle lookup of 0x100 sees pre-update contents
    br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #2;
    chk("cold_misp", {31'd0, bp.MispredictE}, 32'd1);
    chk("cold_redir", bp.RedirectPCE, 32'h80);
    chk("conflict_pred0", {31'd0, bp.PredTakenF}, 32'd0);
    tick();
    idle();
    #2;
    chk("trained_pred", {31'd0, bp.PredTakenF}, 32'd1);
    chk("trained_next", bp.PCNextPredF, 32'h80);
    chk("cold_bcnt", {16'd0, bp.BranchCount}, 32'd1);
    chk("cold_mcnt", {16'd0, bp.MispredCount}, 32'd1);

    // Four correctly predicted taken: ctr 2 -> 3 and holds
    br(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    #2;
    chk("hit_nomisp", {31'd0, bp.MispredictE}, 32'd0);
    repeat (4) tick();
    idle();
    #2;
    chk("sat_bcnt", {16'd0, bp.BranchCount}, 32'd5);
    chk("sat_mcnt", {16'd0, bp.MispredCount}, 32'd1);

    // First not-taken: ctr 3 -> 2, still taken
    br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #2;
    chk("nt1_misp", {31'd0, bp.MispredictE}, 32'd1);
    chk("nt1_redir", bp.RedirectPCE, 32'h104);
    tick();
    idle();
    #2;
    chk("nt1_pred", {31'd0, bp.PredTakenF}, 32'd1);
    // Second not-taken: ctr 2 -> 1, predicted not taken
    br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    idle();
    #2;
    chk("nt2_pred", {31'd0, bp.PredTakenF}, 32'd0);
    chk("nt2_next", bp.PCNextPredF, 32'h104);
    chk("nt2_mcnt", {16'd0, bp.MispredCount}, 32'd3);

    // Retrain to taken (ctr 1 -> 2), then a stale-target mispredict
    br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    br(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    #2;
    chk("tgt_misp", {31'd0, bp.MispredictE}, 32'd1);
    chk("tgt_redir", bp.RedirectPCE, 32'h90);
    tick();
    idle();
    #2;
    chk("tgt_next", bp.PCNextPredF, 32'h90);

    // Aliasing: 0x140 shares index 0 with 0x100 and evicts it
    br(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    tick();
    idle();
    #2;
    chk("alias_old_pred", {31'd0, bp.PredTakenF}, 32'd0);
    chk("alias_old_next", bp.PCNextPredF, 32'h104);
    bp.PCF = 32'h140;
    #1;
    chk("alias_new_pred", {31'd0, bp.PredTakenF}, 32'd1);
    chk("alias_new_next", bp.PCNextPredF, 32'h200);

    // Reset between edges while a branch is in Execute
    br(32'h140, 1'b1, 32'h200, 1'b1, 32'h200);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_pred", {31'd0, bp.PredTakenF}, 32'd0);
    chk("mrst_next", bp.PCNextPredF, 32'h144);
    chk("mrst_bcnt", {16'd0, bp.BranchCount}, 32'd0);
    chk("mrst_mcnt", {16'd0, bp.MispredCount}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #2;
    chk("mrst_after_bcnt", {16'd0, bp.BranchCount}, 32'd0);
    tick();

    // Not-taken miss allocates nothing
    br(32'h200, 1'b0, 32'h300, 1'b0, 32'h204);
    tick();
    idle();
    bp.PCF = 32'h200;
    #2;
    chk("ntmiss_pred", {31'd0, bp.PredTakenF}, 32'd0);
    chk("ntmiss_next", bp.PCNextPredF, 32'h204);
    chk("ntmiss_bcnt", {16'd0, bp.BranchCount}, 32'd1);
    bp.PCF = 32'hFFFF_FFFC;
    #1;
    chk("wrap_next", bp.PCNextPredF, 32'h0);

    // Drive 65535 mispredicts, then one more: both counters pin at 0xFFFF
    br(32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
    repeat (65535) @(posedge clk);
    #1;
    chk("mcnt_full", {16'd0, bp.MispredCount}, 32'hFFFF);
    tick();
    chk("mcnt_hold", {16'd0, bp.MispredCount}, 32'hFFFF);
    chk("bcnt_hold", {16'd0, bp.BranchCount}, 32'hFFFF);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
